// File: rtl/cache_writeback_buffer.sv
// Purpose: queues evicted dirty cache lines, drains them to memory over req/ack, forwards queued data to fill lookups.
// Latency: push visible in count next cycle, mem_req one cycle later; fill lookup answers one cycle after fill_req.
// Backpressure: evict_ready drops when full (registered count); drain holds mem_req until mem_ack. Optional: WB_COALESCE_EN.
module cache_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       evict_valid,
  input  logic [ADDR_W-1:0]          evict_addr,
  input  logic [DATA_W-1:0]          evict_data,
  output logic                       evict_ready,
  input  logic                       fill_req,
  input  logic [ADDR_W-1:0]          fill_addr,
  output logic                       fill_valid,
  output logic                       fill_hit,
  output logic [DATA_W-1:0]          fill_data,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q;
  logic                full;
  logic                head_busy;
  logic                do_pop, do_app, do_co;
  logic                co_hit;
  logic [PW-1:0]       co_idx;
  logic                lk_hit;
  logic [DATA_W-1:0]   lk_data;
  logic [PW-1:0]       lk_idx;

  assign full        = (count_q == CW'(DEPTH));
  assign evict_ready = !full;
  assign count       = count_q;
  assign mem_req     = (state_q == REQ);

  // The head is treated as in flight while being launched (IDLE with data) and while in REQ.
  assign head_busy = (state_q == REQ) || (count_q != '0);

  assign do_pop = (state_q == REQ) && mem_ack;
  assign do_co  = evict_valid && co_hit;
  assign do_app = evict_valid && !full && !co_hit;

  // Lookup across occupied entries oldest to youngest so the youngest match wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_q + PW'(k);
      if (CW'(k) < count_q && addr_q[lk_idx] == fill_addr) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

`ifdef WB_COALESCE_EN
  // Find the youngest occupied entry with the evicted address, skipping the in-flight head.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q && !(k == 0 && head_busy) &&
          addr_q[head_q + PW'(k)] == evict_addr) begin
        co_hit = 1'b1;
        co_idx = head_q + PW'(k);
      end
    end
  end
`else
  assign co_hit = 1'b0;
  assign co_idx = '0;
`endif

  // Drain FSM state register.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Drain FSM next state: launch when data is queued, return to IDLE on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count_q != '0) state_d = REQ;
      REQ:  if (mem_ack)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointers, occupancy and the registered memory write port.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (do_app) tail_q <= tail_q + 1'b1;
      if (do_pop) head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(do_app) - CW'(do_pop);
      if (state_q == IDLE && state_d == REQ) begin
        mem_addr  <= addr_q[head_q];
        mem_wdata <= data_q[head_q];
      end
    end
  end

  // Entry storage: append at tail, or overwrite data of a coalesced entry.
  always_ff @(posedge clock) begin
    if (do_app) begin
      addr_q[tail_q] <= evict_addr;
      data_q[tail_q] <= evict_data;
    end
    if (do_co) begin
      data_q[co_idx] <= evict_data;
    end
  end

  // Fill lookup result, registered one cycle after the request.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      fill_valid <= 1'b0;
      fill_hit   <= 1'b0;
      fill_data  <= '0;
    end else begin
      fill_valid <= fill_req;
      fill_hit   <= fill_req && lk_hit;
      fill_data  <= (fill_req && lk_hit) ? lk_data : '0;
    end
  end

endmodule
